// File: rtl/serial_cascade_comparator.sv
// serial_cascade_comparator: WIDTH-bit magnitude compare, one 3-bit cascade slice per clock, LSB slice first.
// Optional feature macro: COMPARE_SIGNED_EN (two's complement operands when defined).
module serial_cascade_comparator #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  generate
    if (SLICE != 3 || WIDTH < 3 || WIDTH % 3 != 0) begin : g_bad_cfg
      $error("serial_cascade_comparator: WIDTH must be a multiple of 3 and >= 3, SLICE must be 3");
    end
  endgenerate
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       casc_q, casc_d, res_q, res_d, casc_nx, sa, sb;
  logic             busy_q, busy_d, done_q, done_d, last;
  // Current slice of both operands and the cascade value after folding it in
  always_comb begin
    last = (cnt_q == CW'(N - 1));
    sa   = a_q[SLICE*int'(cnt_q) +: SLICE];
    sb   = b_q[SLICE*int'(cnt_q) +: SLICE];
`ifdef COMPARE_SIGNED_EN
    sa   = sa ^ {last, 2'b00};
    sb   = sb ^ {last, 2'b00};
`endif
    casc_nx = (sa > sb) ? 3'b001 : (sa < sb) ? 3'b100 : casc_q;
  end
  // Next-state: accept in IDLE, step one slice per edge in RUN, publish on the last slice
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        a_d     = A;
        b_d     = B;
        casc_d  = 3'b010;
        busy_d  = 1'b1;
      end
    end else begin
      casc_d  = casc_nx;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      res_d   = last ? casc_nx : res_q;
      done_d  = last;
      busy_d  = !last;
      state_d = last ? IDLE : RUN;
    end
  end
  // State registers with immediate abort on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign lt   = res_q[2];
  assign eq   = res_q[1];
  assign gt   = res_q[0];
endmodule

// File: tb/tb_serial_cascade_comparator.sv
// tb_serial_cascade_comparator: directed checks of the serial cascade comparator (WIDTH=12).
module tb_serial_cascade_comparator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] A = '0;
  logic [11:0] B = '0;
  logic        busy, done, lt, eq, gt;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [2:0]  prev = 3'b000;

  serial_cascade_comparator #(.WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, lt, eq, gt} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset: busy/done/lt/eq/gt=%b required 00000", {busy, done, lt, eq, gt});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_compare(input string name, input logic [11:0] a, input logic [11:0] b,
                              input logic [2:0] exp);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    A = ~a;
    B = ~b;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || {lt, eq, gt} !== prev) begin
        n_bad++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b res=%b required busy=1 done=0 res=%b",
                 name, i, busy, done, {lt, eq, gt}, prev);
      end
      if (i < 4) @(posedge clk);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || {lt, eq, gt} !== exp) begin
      n_bad++;
      $display("FAIL %s done: done=%b busy=%b lt/eq/gt=%b required done=1 busy=0 lt/eq/gt=%b",
               name, done, busy, {lt, eq, gt}, exp);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || {lt, eq, gt} !== exp) begin
      n_bad++;
      $display("FAIL %s after: done=%b lt/eq/gt=%b required done=0 lt/eq/gt=%b",
               name, done, {lt, eq, gt}, exp);
    end
    prev = exp;
  endtask

  task automatic test_back_to_back();
    logic exp_done, exp_busy;
    A = 12'd1;
    B = 12'd2;
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 9) start = 1'b0;
      exp_done = (i == 4) || (i == 9);
      exp_busy = (i < 4) || (i >= 5 && i < 9);
      n_vec++;
      if (done !== exp_done || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: done=%b busy=%b required done=%b busy=%b",
                 i, done, busy, exp_done, exp_busy);
      end
      if (exp_done) begin
        n_vec++;
        if ({lt, eq, gt} !== 3'b100) begin
          n_bad++;
          $display("FAIL back_to_back result cycle %0d: lt/eq/gt=%b required 100", i, {lt, eq, gt});
        end
      end
    end
    prev = 3'b100;
  endtask

  task automatic test_abort();
    A = 12'd5;
    B = 12'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, lt, eq, gt} !== 5'b0) begin
      n_bad++;
      $display("FAIL abort: busy/done/lt/eq/gt=%b required 00000", {busy, done, lt, eq, gt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, lt, eq, gt} !== 5'b0) begin
        n_bad++;
        $display("FAIL abort_release cycle %0d: busy/done/lt/eq/gt=%b required 00000",
                 i, {busy, done, lt, eq, gt});
      end
    end
    prev = 3'b000;
  endtask

  initial begin
    test_reset();
    test_compare("equal", 12'h001, 12'h001, 3'b010);
    test_compare("lsb_gt", 12'h002, 12'h001, 3'b001);
    test_compare("override", 12'h100, 12'h0FF, 3'b001);
    test_compare("msb_lt", 12'h0FF, 12'h100, 3'b100);
`ifdef COMPARE_SIGNED_EN
    test_compare("sign", 12'h801, 12'h7FF, 3'b100);
    test_compare("neg_neg", 12'hFFE, 12'hFFF, 3'b100);
`else
    test_compare("sign", 12'h801, 12'h7FF, 3'b001);
    test_compare("neg_neg", 12'hFFE, 12'hFFF, 3'b100);
`endif
    test_compare("max_eq", 12'hFFF, 12'hFFF, 3'b010);
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
